// File: rtl/gen_sram8_pkg.sv
// Shared definitions for the asynchronous 8-bit SRAM cycle generator.
package gen_sram8_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_HOLD   = 3'd3,
    ST_ACK    = 3'd4,
    ST_RECOV  = 3'd5
  } state_t;

  // Pick byte lane `lane` out of a 32-bit word.
  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/gen_sram8.sv
// Converts a single-beat dev_* req/ack transfer into a timed SETUP/ACCESS/HOLD
// cycle on an external asynchronous 8-bit SRAM, followed by an ack pulse and a
// bus recovery gap. All outputs are registered.
module gen_sram8
  import gen_sram8_pkg::*;
#(
  parameter int p_aw     = 19,
  parameter int p_setup  = 1,
  parameter int p_access = 3,
  parameter int p_hold   = 1,
  parameter int p_turn   = 1
) (
  input  logic              dev_clk,
  input  logic              dev_rst_n,
  input  logic [31:0]       dev_addr,
  input  logic [31:0]       dev_wdata,
  input  logic [3:0]        dev_be,
  input  logic              dev_wr,
  input  logic              dev_req,
  output logic              dev_ack,
  output logic [31:0]       dev_rdata,
  output logic [p_aw-1:0]   sram_a,
  output logic [7:0]        sram_d_o,
  output logic              sram_d_oe,
  input  logic [7:0]        sram_d_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  if (p_setup < 0 || p_setup > 15) begin : g_bad_setup
    $error("gen_sram8: p_setup must be 0..15");
  end
  if (p_access < 1 || p_access > 15) begin : g_bad_access
    $error("gen_sram8: p_access must be 1..15");
  end
  if (p_hold < 0 || p_hold > 15) begin : g_bad_hold
    $error("gen_sram8: p_hold must be 0..15");
  end
  if (p_turn < 1 || p_turn > 15) begin : g_bad_turn
    $error("gen_sram8: p_turn must be 1..15");
  end

  localparam logic [3:0] LD_SETUP  = 4'(p_setup - 1);
  localparam logic [3:0] LD_ACCESS = 4'(p_access - 1);
  localparam logic [3:0] LD_HOLD   = 4'(p_hold - 1);
  localparam logic [3:0] LD_TURN   = 4'(p_turn - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       wr_q, be_q;
  logic [7:0] rbyte_q;
  logic       take, wr_d, be_d, active;

  // Upper address bits alias onto the SRAM space by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^dev_addr[31:p_aw];

  // Next state and wait-counter reload; zero-length phases are skipped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (dev_req) begin
          if (p_setup != 0) begin
            state_d = ST_SETUP;
            cnt_d   = LD_SETUP;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = LD_ACCESS;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_ACCESS;
          cnt_d   = LD_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          if (p_hold != 0) begin
            state_d = ST_HOLD;
            cnt_d   = LD_HOLD;
          end else begin
            state_d = ST_ACK;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_ACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_RECOV;
        cnt_d   = LD_TURN;
      end
      ST_RECOV: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Command attributes as they will be seen in the next state, so outputs can be registered.
  always_comb begin
    take   = (state_q == ST_IDLE) && dev_req;
    wr_d   = take ? dev_wr : wr_q;
    be_d   = take ? dev_be[dev_addr[1:0]] : be_q;
    active = (state_d == ST_SETUP) || (state_d == ST_ACCESS) || (state_d == ST_HOLD);
  end

  // FSM state and wait counter.
  always_ff @(posedge dev_clk or negedge dev_rst_n) begin
    if (!dev_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Command capture, registered pad strobes, read byte capture and ack.
  always_ff @(posedge dev_clk or negedge dev_rst_n) begin
    if (!dev_rst_n) begin
      sram_a    <= '0;
      sram_d_o  <= '0;
      wr_q      <= 1'b0;
      be_q      <= 1'b0;
      rbyte_q   <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_d_oe <= 1'b0;
      dev_ack   <= 1'b0;
      dev_rdata <= '0;
    end else begin
      if (take) begin
        sram_a   <= dev_addr[p_aw-1:0];
        sram_d_o <= lane_byte(dev_wdata, dev_addr[1:0]);
        wr_q     <= dev_wr;
        be_q     <= dev_be[dev_addr[1:0]];
      end
      sram_ce_n <= !active;
      sram_oe_n <= !(active && !wr_d);
      sram_d_oe <= active && wr_d;
      sram_we_n <= !((state_d == ST_ACCESS) && wr_d && be_d);
      dev_ack   <= (state_d == ST_ACK);
      if ((state_q == ST_ACCESS) && (cnt_q == '0) && !wr_q) begin
        rbyte_q <= sram_d_i;
      end
      // With no HOLD phase the capture edge is also the ACK entry edge, so take the pad directly.
      if ((state_d == ST_ACK) && !wr_q) begin
        dev_rdata <= {4{(state_q == ST_ACCESS) ? sram_d_i : rbyte_q}};
      end
    end
  end

endmodule
